// File: rtl/joybus_poll_sched.sv
// joybus_poll_sched
// Sequences JOYBUS host transactions. Every POLL_PERIOD cycles one command
// byte goes to the host transceiver: 0x00 (info) while no controller is
// present, 0x01 (poll buttons) once one is. Response bytes are collected
// under a timeout, and ID, status and button state are published.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         polling enable (sampled only while waiting for the period)
//   cmd_data   command byte, valid with cmd_rdy, held until the next command
//   cmd_rdy    one-cycle command strobe
//   tx_done    host pulse: command fully transmitted
//   resp_data  response byte from host, valid with resp_vld
//   resp_vld   one-cycle response byte strobe
//   present    standard controller (ID 0x0500) detected
//   dev_id     last info-response ID, first byte in [15:8]
//   dev_stat   last info-response status byte
//   buttons    last poll response, first byte in [31:24]
//   btn_vld    one-cycle pulse when buttons is updated
//   err_cnt    failed-transaction count, saturating at 255
//   busy       high whenever a transaction is in progress
module joybus_poll_sched #(
  parameter int POLL_PERIOD  = 416667,
  parameter int RESP_TIMEOUT = 2500,
  parameter int TX_TIMEOUT   = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [7:0]  cmd_data,
  output logic        cmd_rdy,
  input  logic        tx_done,
  input  logic [7:0]  resp_data,
  input  logic        resp_vld,
  output logic        present,
  output logic [15:0] dev_id,
  output logic [7:0]  dev_stat,
  output logic [31:0] buttons,
  output logic        btn_vld,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int CW   = $clog2(POLL_PERIOD + 1);
  localparam int TMAX = (RESP_TIMEOUT > TX_TIMEOUT) ? RESP_TIMEOUT : TX_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] PER_RELOAD = CW'(POLL_PERIOD - 1);
  // The timeout counter is compared one short of the limit so the FAIL
  // state is entered on the edge where the count reaches the limit.
  localparam logic [TW-1:0] TX_LAST    = TW'(TX_TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST  = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_WAIT, S_ISSUE, S_TX, S_RX, S_DONE, S_FAIL
  } state_t;

  state_t        state_q;
  logic [CW-1:0] per_q;
  logic [TW-1:0] tmo_q;
  logic [2:0]    nbyte_q;
  logic [2:0]    len_q;
  logic          is_poll_q;
  logic [23:0]   asm_q;      // previous three bytes; the newest byte completes the word
  logic [7:0]    cmd_data_q;
  logic          cmd_rdy_q;
  logic          present_q;
  logic [15:0]   dev_id_q;
  logic [7:0]    dev_stat_q;
  logic [31:0]   buttons_q;
  logic          btn_vld_q;
  logic [7:0]    err_cnt_q;

  logic [31:0]   asm_d;
  logic [2:0]    nbyte_d;

  assign asm_d   = {asm_q, resp_data};
  assign nbyte_d = nbyte_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      per_q      <= PER_RELOAD;
      tmo_q      <= '0;
      nbyte_q    <= '0;
      len_q      <= '0;
      is_poll_q  <= 1'b0;
      asm_q      <= '0;
      cmd_data_q <= '0;
      cmd_rdy_q  <= 1'b0;
      present_q  <= 1'b0;
      dev_id_q   <= '0;
      dev_stat_q <= '0;
      buttons_q  <= '0;
      btn_vld_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      cmd_rdy_q <= 1'b0;
      btn_vld_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (!en) begin
            per_q <= PER_RELOAD;
          end else if (per_q == '0) begin
            state_q    <= S_ISSUE;
            cmd_rdy_q  <= 1'b1;
            cmd_data_q <= {7'd0, present_q};
            is_poll_q  <= present_q;
            len_q      <= present_q ? 3'd4 : 3'd3;
          end else begin
            per_q <= per_q - 1'b1;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_TX;
        end
        S_TX: begin
          // tx_done takes priority over an expiring timeout
          if (tx_done) begin
            state_q <= S_RX;
            nbyte_q <= '0;
            tmo_q   <= '0;
          end else if (tmo_q == TX_LAST) begin
            state_q   <= S_FAIL;
            present_q <= 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RX: begin
          // an arriving byte takes priority over an expiring timeout
          if (resp_vld) begin
            asm_q   <= asm_d[23:0];
            nbyte_q <= nbyte_d;
            tmo_q   <= '0;
            if (nbyte_d == len_q) begin
              state_q <= S_DONE;
              if (is_poll_q) begin
                buttons_q <= asm_d;
                btn_vld_q <= 1'b1;
              end else begin
                dev_id_q   <= asm_d[23:8];
                dev_stat_q <= asm_d[7:0];
                present_q  <= (asm_d[23:8] == 16'h0500);
              end
            end
          end else if (tmo_q == RESP_LAST) begin
            state_q   <= S_FAIL;
            present_q <= 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DONE, S_FAIL: begin
          // period restarts on exit, so cadence is period plus transaction length
          per_q   <= PER_RELOAD;
          state_q <= S_WAIT;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign cmd_data = cmd_data_q;
  assign cmd_rdy  = cmd_rdy_q;
  assign present  = present_q;
  assign dev_id   = dev_id_q;
  assign dev_stat = dev_stat_q;
  assign buttons  = buttons_q;
  assign btn_vld  = btn_vld_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = (state_q != S_WAIT);

endmodule

// File: tb/tb_joybus_poll_sched.sv
// Scoreboard bench for joybus_poll_sched. The stimulus thread pushes the
// expected outcome of each transaction; a monitor on the falling clock edge
// checks cmd_data on every cmd_rdy and the published outputs when busy drops.
module tb_joybus_poll_sched;

  localparam int PP = 100;
  localparam int RT = 50;
  localparam int TT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        tx_done = 1'b0;
  logic        resp_vld = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic [7:0]  cmd_data;
  logic        cmd_rdy;
  logic        present;
  logic [15:0] dev_id;
  logic [7:0]  dev_stat;
  logic [31:0] buttons;
  logic        btn_vld;
  logic [7:0]  err_cnt;
  logic        busy;

  joybus_poll_sched #(
    .POLL_PERIOD(PP), .RESP_TIMEOUT(RT), .TX_TIMEOUT(TT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cmd_data(cmd_data), .cmd_rdy(cmd_rdy), .tx_done(tx_done),
    .resp_data(resp_data), .resp_vld(resp_vld),
    .present(present), .dev_id(dev_id), .dev_stat(dev_stat),
    .buttons(buttons), .btn_vld(btn_vld), .err_cnt(err_cnt), .busy(busy)
  );

  always #20 clk = ~clk;  // 25 MHz

  typedef struct {
    logic [7:0]  cmd;
    logic        present;
    logic [15:0] id;
    logic [7:0]  stat;
    logic [31:0] btn;
    logic [7:0]  err;
    int          pulses;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference state of the published outputs
  logic        m_present = 1'b0;
  logic [15:0] m_id = 16'h0;
  logic [7:0]  m_stat = 8'h0;
  logic [31:0] m_btn = 32'h0;
  int          m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- monitor ----------------
  logic busy_prev = 1'b0;
  logic rdy_prev = 1'b0;
  int   pulses = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_prev = 1'b0;
      rdy_prev  = 1'b0;
      pulses    = 0;
      sb_q.delete();
    end else begin
      if (rdy_prev) check("cmd_rdy_width", {31'd0, cmd_rdy}, 32'd0);
      if (cmd_rdy) begin
        if (sb_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
        else check("cmd_data", {24'd0, cmd_data}, {24'd0, sb_q[0].cmd});
      end
      if (btn_vld) pulses++;
      if (busy_prev && !busy) begin
        if (sb_q.size() == 0) begin
          check("txn_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("present",  {31'd0, present}, {31'd0, e.present});
          check("dev_id",   {16'd0, dev_id},  {16'd0, e.id});
          check("dev_stat", {24'd0, dev_stat}, {24'd0, e.stat});
          check("buttons",  buttons, e.btn);
          check("err_cnt",  {24'd0, err_cnt}, {24'd0, e.err});
          check("btn_vld_pulses", pulses, e.pulses);
          $display("txn cmd=%02h present=%0b id=%04h stat=%02h btn=%08h err=%0d",
                   e.cmd, present, dev_id, dev_stat, buttons, err_cnt);
        end
        pulses = 0;
      end
      busy_prev = busy;
      rdy_prev  = cmd_rdy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cmd(output int n);
    n = 0;
    while (!cmd_rdy && n < 2000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) check("cmd_rdy_timeout", 32'd0, 32'd1);
  endtask

  // tx_dly < 0 means tx_done is never sent; bytes holds the first byte in [31:24]
  task automatic run_txn(input logic [7:0] exp_cmd, input int tx_dly,
                         input logic [31:0] bytes, input int nb, input int gap,
                         output int cmd_cyc, output int end_cyc);
    exp_t e;
    logic poll;
    int   len;
    poll = m_present;
    len  = poll ? 4 : 3;
    if (tx_dly >= 0 && nb >= len) begin
      if (poll) begin
        m_btn = bytes;
      end else begin
        m_id      = bytes[31:16];
        m_stat    = bytes[15:8];
        m_present = (bytes[31:16] == 16'h0500);
      end
    end else begin
      m_present = 1'b0;
      if (m_err < 255) m_err++;
    end
    e.cmd = exp_cmd; e.present = m_present; e.id = m_id; e.stat = m_stat;
    e.btn = m_btn; e.err = 8'(m_err);
    e.pulses = (poll && tx_dly >= 0 && nb >= len) ? 1 : 0;
    sb_q.push_back(e);

    wait_cmd(cmd_cyc);
    end_cyc = 0;
    if (tx_dly >= 0) begin
      repeat (tx_dly) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      for (int i = 0; i < nb; i++) begin
        repeat (gap) @(negedge clk);
        resp_data = bytes[31-8*i -: 8];
        resp_vld  = 1'b1;
        @(negedge clk);
        resp_vld  = 1'b0;
      end
    end
    while (busy && end_cyc < 3000) begin
      @(negedge clk);
      end_cyc++;
    end
    if (busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_data"}, {24'd0, cmd_data}, 32'd0);
    check({tag, "_cmd_rdy"},  {31'd0, cmd_rdy}, 32'd0);
    check({tag, "_present"},  {31'd0, present}, 32'd0);
    check({tag, "_dev_id"},   {16'd0, dev_id}, 32'd0);
    check({tag, "_dev_stat"}, {24'd0, dev_stat}, 32'd0);
    check({tag, "_buttons"},  buttons, 32'd0);
    check({tag, "_btn_vld"},  {31'd0, btn_vld}, 32'd0);
    check({tag, "_err_cnt"},  {24'd0, err_cnt}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cc, fc, seen;
    exp_t d;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    en  = 1'b1;
    rst = 1'b0;

    // 1: info response 05 00 01, first command exactly PP cycles after reset
    run_txn(8'h00, 20, 32'h0500_0100, 3, 2, cc, fc);
    check("first_cmd_latency", cc, PP);
    // 2: poll response
    run_txn(8'h01, 5, 32'h8000_7F81, 4, 1, cc, fc);
    check("cadence_after_done", cc, PP);
    // 3: poll with no response bytes
    run_txn(8'h01, 3, 32'h0, 0, 1, cc, fc);
    check_rng("resp_timeout_cycles", fc, RT, RT + 2);
    // 4: non-standard ID, then no tx_done
    run_txn(8'h00, 4, 32'h0005_0000, 3, 2, cc, fc);
    run_txn(8'h00, -1, 32'h0, 0, 1, cc, fc);
    check_rng("tx_timeout_cycles", fc, TT - 1, TT + 3);
    check("cadence_after_fail", cc, PP);
    // 5: re-detect, then a truncated poll, then saturate err_cnt
    run_txn(8'h00, 2, 32'h0500_0100, 3, 2, cc, fc);
    run_txn(8'h01, 2, 32'h1234_0000, 2, 3, cc, fc);
    for (int i = 0; i < 260; i++) run_txn(8'h00, 1, 32'h0, 0, 1, cc, fc);
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
    // 6: reset in the middle of a poll's RX phase
    run_txn(8'h00, 2, 32'h0500_0100, 3, 2, cc, fc);
    d.cmd = 8'h01; d.present = 1'b0; d.id = 16'h0; d.stat = 8'h0;
    d.btn = 32'h0; d.err = 8'h0; d.pulses = 0;
    sb_q.push_back(d);
    wait_cmd(cc);
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    resp_data = 8'h80;
    resp_vld  = 1'b1;
    @(negedge clk);
    resp_vld  = 1'b0;
    #5 rst = 1'b1;
    #1 check_all_zero("mid_rx_reset");
    m_present = 1'b0; m_id = 16'h0; m_stat = 8'h0; m_btn = 32'h0; m_err = 0;
    repeat (3) @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_rdy) seen++;
    end
    check("cmd_while_disabled", seen, 0);
    en = 1'b1;
    run_txn(8'h00, 3, 32'h0500_0100, 3, 2, cc, fc);
    check("cmd_latency_after_en", cc, PP);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
